// File: rtl/apb2csb_pkg.sv
// Shared types and helpers for the parametrised APB3-to-CSB bridge.
// Holds the read FSM states, the default write-buffer entry and the window hit check.
package apb2csb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP
  } rd_state_e;

  localparam int unsigned CSB_AW_DEF   = 16;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_0BAD;

  typedef struct packed {
    logic [CSB_AW_DEF-1:0] addr;
    logic [31:0]           wdat;
  } wbuf_entry_t;

  // Word-aligned access that falls inside the power-of-2 window at base.
  function automatic logic is_hit(input logic [31:0] paddr,
                                  input logic [31:0] base,
                                  input logic [31:0] win_bytes);
    return ((paddr & ~(win_bytes - 32'd1)) == base) && (paddr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb2csb_wbuf.sv
// Posted-write FIFO: DEPTH entries, wrap-bit pointers, registered full/empty/count.
module apb2csb_wbuf
  import apb2csb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = wbuf_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t      mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, count_nxt;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // Flags are registered so the APB ready path never sees csb2nvdla_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/apb2csb_bridge_pw.sv
// APB3 slave to NVDLA CSB master: zero-wait posted writes through a FIFO,
// non-posted reads that drain the FIFO first and time out into pslverr.
module apb2csb_bridge_pw
  import apb2csb_pkg::*;
#(
  parameter int unsigned CSB_AW     = 16,
  parameter int unsigned WR_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] WIN_BYTES  = 32'(2**(CSB_AW+2)),
  parameter int unsigned RD_TIMEOUT = 1023,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              csb2nvdla_valid,
  input  logic              csb2nvdla_ready,
  output logic [CSB_AW-1:0] csb2nvdla_addr,
  output logic [31:0]       csb2nvdla_wdat,
  output logic              csb2nvdla_write,
  output logic              csb2nvdla_nposted,
  input  logic              nvdla2csb_valid,
  input  logic [31:0]       nvdla2csb_data,
  output logic              bridge_idle
);
  typedef struct packed {
    logic [CSB_AW-1:0] addr;
    logic [31:0]       wdat;
  } entry_t;

  localparam int unsigned TW  = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO = TW'(RD_TIMEOUT);

  rd_state_e                 state, state_nxt;
  logic                      in_idle, hit, miss, wr_hit, rd_hit, tmo_hit;
  logic                      push, pop, full, empty;
  logic [$clog2(WR_DEPTH):0] count;
  entry_t                    push_ent, head;
  logic [CSB_AW-1:0]         rd_addr;
  logic [TW-1:0]             timer;
  logic                      drop_pend, rd_err;
  logic [31:0]               rd_data;

  // New APB accesses are only decoded in IDLE; a read holds the bus until RESP.
  assign in_idle  = (state == ST_IDLE);
  assign hit      = is_hit(paddr, BASE_ADDR, WIN_BYTES);
  assign miss     = psel && penable && in_idle && !hit;
  assign wr_hit   = psel && penable && in_idle && hit && pwrite;
  assign rd_hit   = psel && penable && in_idle && hit && !pwrite;
  assign push     = wr_hit && !full;
  assign push_ent = '{addr: paddr[CSB_AW+1:2], wdat: pwdata};
  assign pop      = !empty && (state != ST_RD_REQ) && csb2nvdla_ready;
  assign tmo_hit  = (RD_TIMEOUT != 0) && (timer == TMO);

  apb2csb_wbuf #(.DEPTH(WR_DEPTH), .entry_t(entry_t)) u_wbuf (
    .clk   (pclk),
    .rst   (prst),
    .push  (push),
    .wdata (push_ent),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (rd_hit) state_nxt = empty ? ST_RD_REQ : ST_RD_DRAIN;
      ST_RD_DRAIN: if (empty) state_nxt = ST_RD_REQ;
      ST_RD_REQ:   if (csb2nvdla_ready) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  if ((nvdla2csb_valid && !drop_pend) || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      timer     <= '0;
      drop_pend <= 1'b0;
      rd_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= state_nxt;
      if (rd_hit) rd_addr <= paddr[CSB_AW+1:2];
      timer <= (state == ST_RD_WAIT) ? timer + 1'b1 : '0;
      // A stale response owed to a timed-out read is swallowed wherever it lands.
      if (nvdla2csb_valid && drop_pend) drop_pend <= 1'b0;
      if (state == ST_RD_WAIT) begin
        if (nvdla2csb_valid && !drop_pend) begin
          rd_data <= nvdla2csb_data;
          rd_err  <= 1'b0;
        end else if (tmo_hit) begin
          rd_data   <= ERR_DATA;
          rd_err    <= 1'b1;
          drop_pend <= 1'b1;
        end
      end
      if (miss) rd_data <= ERR_DATA;
    end
  end

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = rd_data;
    if (state == ST_RESP) begin
      pready  = 1'b1;
      pslverr = rd_err;
    end else if (miss) begin
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = ERR_DATA;
    end else if (wr_hit) begin
      pready  = !full;
    end
  end

  always_comb begin
    csb2nvdla_valid = 1'b0;
    csb2nvdla_addr  = '0;
    csb2nvdla_wdat  = '0;
    csb2nvdla_write = 1'b0;
    if (state == ST_RD_REQ) begin
      csb2nvdla_valid = 1'b1;
      csb2nvdla_addr  = rd_addr;
    end else if (!empty) begin
      csb2nvdla_valid = 1'b1;
      csb2nvdla_write = 1'b1;
      csb2nvdla_addr  = head.addr;
      csb2nvdla_wdat  = head.wdat;
    end
  end

  assign csb2nvdla_nposted = 1'b0;
  assign bridge_idle       = (count == '0) && in_idle;

endmodule
